// File: rtl/mux32b_sel.sv
// mux32b_sel: 2:1 word select with registered copy, valid flag and select-change counter.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   Src1, Src2      operands; choose=0 picks Src1, choose=1 picks Src2
//   choose          select
//   in_valid        qualifies operands/select for the registered path
//   result          combinational select
//   result_q        registered select, loaded on in_valid cycles
//   out_valid       result_q was loaded on the previous edge
//   sel_toggle_cnt  saturating count of registered-select changes
//   result_par      (only with MUX32B_PARITY_EN) XOR-reduction of the value loaded into result_q
module mux32b_sel #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] Src1,
    input  logic [WIDTH-1:0] Src2,
    input  logic             choose,
    input  logic             in_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] sel_toggle_cnt
`ifdef MUX32B_PARITY_EN
    ,
    output logic             result_par
`endif
);
    logic sel_q;
    assign result = choose ? Src2 : Src1;
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q       <= '0;
            out_valid      <= 1'b0;
            sel_q          <= 1'b0;
            sel_toggle_cnt <= '0;
        end else if (in_valid) begin
            result_q  <= result;
            out_valid <= 1'b1;
            sel_q     <= choose;
            // counter sticks at all-ones rather than wrapping
            if (choose != sel_q && !(&sel_toggle_cnt))
                sel_toggle_cnt <= sel_toggle_cnt + 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end
`ifdef MUX32B_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst)
            result_par <= 1'b0;
        else if (in_valid)
            result_par <= ^result;
    end
`endif
endmodule

// File: tb/tb_mux32b_sel.sv
// tb_mux32b_sel: directed self-checking bench for mux32b_sel.
module tb_mux32b_sel;
    localparam int WIDTH = 32;
    localparam int CNT_W = 3;
    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic             choose;
    logic             in_valid;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_q;
    logic             out_valid;
    logic [CNT_W-1:0] sel_toggle_cnt;
`ifdef MUX32B_PARITY_EN
    logic             result_par;
`endif
    int checks = 0;
    int fails  = 0;
    mux32b_sel #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .Src1(src1),
        .Src2(src2),
        .choose(choose),
        .in_valid(in_valid),
        .result(result),
        .result_q(result_q),
        .out_valid(out_valid),
        .sel_toggle_cnt(sel_toggle_cnt)
`ifdef MUX32B_PARITY_EN
        ,
        .result_par(result_par)
`endif
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    initial begin
        int seq[5] = '{0, 1, 1, 0, 1};
        rst = 1'b1;
        in_valid = 1'b0;
        choose = 1'b0;
        src1 = 32'h0001_2345;
        src2 = 32'h0005_4321;
        #1;
        check("comb_sel0", result, 32'h0001_2345);
        src1 = 32'h0006_789A;
        src2 = 32'h000A_9876;
        choose = 1'b1;
        #1;
        check("comb_sel1", result, 32'h000A_9876);
        repeat (2) tick();
        check("rst_result_q", result_q, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_cnt", sel_toggle_cnt, 0);
        rst = 1'b0;
        in_valid = 1'b1;
        choose = 1'b1;
        src1 = 32'h1111_1111;
        src2 = 32'hDEAD_BEEF;
        tick();
        check("cap_result_q", result_q, 32'hDEAD_BEEF);
        check("cap_out_valid", out_valid, 1);
        check("cap_cnt", sel_toggle_cnt, 1);
        in_valid = 1'b0;
        choose = 1'b0;
        src2 = 32'h0;
        tick();
        check("idle_out_valid", out_valid, 0);
        check("idle_hold", result_q, 32'hDEAD_BEEF);
        check("idle_no_count", sel_toggle_cnt, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            choose = seq[i][0];
            src1 = 32'h10 + i;
            src2 = 32'h20 + i;
            tick();
            check("seq_result_q", result_q, seq[i] ? 32'h20 + i : 32'h10 + i);
        end
        check("seq_cnt", sel_toggle_cnt, 3);
        in_valid = 1'b0;
        choose = 1'b0;
        tick();
        check("seq_idle_cnt", sel_toggle_cnt, 3);
        in_valid = 1'b1;
        tick();
        check("seq_held_sel_cnt", sel_toggle_cnt, 4);
        for (int i = 0; i < 6; i++) begin
            choose = ~choose;
            tick();
        end
        check("cnt_saturate", sel_toggle_cnt, 7);
        choose = 1'b0;
        src1 = 32'h0000_0007;
        tick();
        check("par7_result_q", result_q, 7);
`ifdef MUX32B_PARITY_EN
        check("par7", result_par, 1);
`endif
        src1 = 32'h0000_0003;
        tick();
        check("par3_result_q", result_q, 3);
`ifdef MUX32B_PARITY_EN
        check("par3", result_par, 0);
`endif
        rst = 1'b1;
        in_valid = 1'b1;
        choose = 1'b1;
        src2 = 32'hCAFE_F00D;
        #1;
        check("srst_comb_pre", result, 32'hCAFE_F00D);
        tick();
        check("srst_result_q", result_q, 0);
        check("srst_out_valid", out_valid, 0);
        check("srst_cnt", sel_toggle_cnt, 0);
`ifdef MUX32B_PARITY_EN
        check("srst_par", result_par, 0);
`endif
        check("srst_comb_post", result, 32'hCAFE_F00D);
        choose = 1'b0;
        src1 = 32'h0000_0012;
        #1;
        check("srst_comb_track", result, 32'h12);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
